muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide operations, attached to the EX stage beside the main ALU.
- Accepts one operation from EX and holds the pipeline stalled while a radix-2 shift-add / restoring-divide datapath iterates.
- Delivers the 32-bit result with a one-cycle done pulse.
- Supports pipeline flush mid-operation.

---
 rtl/muldiv_seq.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
// It uses a radix-2 datapath: a shift-add multiplier and a restoring divider.
// Each operation takes one iteration per cycle, XLEN iterations in total.
// Divide-by-zero and signed overflow skip the iterations and complete one cycle after start.
// Optional build macro MULDIV_RESULT_CACHE_EN: reuse the result of the last completed operation.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op;
  logic [XLEN-1:0]   opnd;      // multiplicand, or divisor magnitude
  logic [2*XLEN-1:0] acc;       // {hi, lo} product, or {remainder, quotient}
  logic [CW-1:0]     cnt;
  logic              neg_q;     // product / quotient sign
  logic              neg_r;     // remainder sign (follows the dividend)

  // Pick the architectural result out of a fixed-up accumulator.
  function automatic logic [XLEN-1:0] sel_res(input logic [2:0] f, input logic [2*XLEN-1:0] a);
    logic lo;
    lo = (f == F_MUL) || (f[2] && !f[1]);
    return lo ? a[XLEN-1:0] : a[2*XLEN-1:XLEN];
  endfunction

  // Decode the incoming request: operand magnitudes, result signs, and bypass cases.
  logic            a_sgn, b_sgn, div0, ovf, accept;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  always_comb begin
    a_sgn    = rs1_val[XLEN-1] &&
               (funct3 == F_MULH || funct3 == F_MULHSU || funct3 == F_DIV || funct3 == F_REM);
    b_sgn    = rs2_val[XLEN-1] && (funct3 == F_MULH || funct3 == F_DIV || funct3 == F_REM);
    a_mag    = a_sgn ? -rs1_val : rs1_val;
    b_mag    = b_sgn ? -rs2_val : rs2_val;
    div0     = funct3[2] && (rs2_val == '0);
    ovf      = (funct3 == F_DIV || funct3 == F_REM) && (rs1_val == SMIN) && (rs2_val == '1);
    spec_res = '0;
    if (div0)     spec_res = funct3[1] ? rs1_val : '1;
    else if (ovf) spec_res = funct3[1] ? '0 : SMIN;
    accept   = start && !flush && (state == IDLE || state == DONE);
  end

  // One datapath iteration, plus the sign fix-up applied on the final one.
  logic [XLEN:0]     mul_sum, div_part, div_diff;
  logic [2*XLEN-1:0] acc_nx, prod_fix, fix_acc;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_part = acc[2*XLEN-1:XLEN-1];
    div_diff = div_part - {1'b0, opnd};
    if (!op[2])
      acc_nx = {mul_sum, acc[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_nx = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nx = {div_part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    prod_fix = neg_q ? -acc_nx : acc_nx;
    quo_fix  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem_fix  = neg_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    fix_acc  = op[2] ? {rem_fix, quo_fix} : prod_fix;
  end

  logic            hit;
  logic [XLEN-1:0] cache_res;
`ifdef MULDIV_RESULT_CACHE_EN
  logic              c_vld;
  logic [2:0]        c_f3, k_f3;
  logic [XLEN-1:0]   c_rs1, c_rs2, k_rs1, k_rs2;
  logic [2*XLEN-1:0] c_acc;

  // A hit is the same request, or a MUL whose product a cached MULH* already holds.
  always_comb begin
    hit = c_vld && (rs1_val == c_rs1) && (rs2_val == c_rs2) &&
          ((funct3 == c_f3) || (funct3 == F_MUL && !c_f3[2]));
    cache_res = sel_res(funct3, c_acc);
  end

  // Keep the key of the op in flight, and commit it when that op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_f3  <= '0;
      c_rs1 <= '0;
      c_rs2 <= '0;
      c_acc <= '0;
      k_f3  <= '0;
      k_rs1 <= '0;
      k_rs2 <= '0;
    end else begin
      if (accept) begin
        k_f3  <= funct3;
        k_rs1 <= rs1_val;
        k_rs2 <= rs2_val;
      end
      if (flush && state == CALC) begin
        c_vld <= 1'b0;
      end else if (!flush && state == CALC && cnt == '0) begin
        c_vld <= 1'b1;
        c_f3  <= k_f3;
        c_rs1 <= k_rs1;
        c_rs2 <= k_rs2;
        c_acc <= fix_acc;
      end
    end
  end
`else
  always_comb begin
    hit       = 1'b0;
    cache_res = '0;
  end
`endif

  // Control FSM: it accepts in IDLE or DONE, iterates in CALC, and flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= '0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              op    <= funct3;
              neg_q <= a_sgn ^ b_sgn;
              neg_r <= a_sgn;
              if (div0 || ovf) begin
                result <= spec_res;
                done   <= 1'b1;
                state  <= DONE;
              end else if (hit) begin
                result <= cache_res;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                opnd  <= funct3[2] ? b_mag : a_mag;
                acc   <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                cnt   <= CW'(XLEN - 1);
                state <= CALC;
              end
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              acc    <= fix_acc;
              result <= sel_res(op, fix_acc);
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              acc <= acc_nx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign stall_req = (state == IDLE && start) || (state == CALC);
  assign busy      = (state == CALC);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: fixed vectors with hand-computed results and latencies.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        flush = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_RESULT_CACHE_EN
  localparam int CACHE_LAT = 1;
`else
  localparam int CACHE_LAT = 33;
`endif

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count edges until done appears.
  // Stall must stay high on every cycle before done.
  task automatic wait_done(input int lat0, output int lat, output bit seen, output bit stall_ok);
    lat = lat0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && lat < 60) begin
      @(posedge clk); lat++;
      #1 start = 1'b0;
      if (done) seen = 1'b1;
      else if (!stall_req) stall_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, b,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat; bit seen, sok;
    @(posedge clk); @(negedge clk);
    funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1;
    #1 chk({tag, "_stall_at_start"}, 32'(stall_req), 32'd1);
    wait_done(0, lat, seen, sok);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_stall_before_done"}, 32'(sok), 32'd1);
    chk({tag, "_stall_low_in_done"}, 32'(stall_req), 32'd0);
  endtask

  // Watch n cycles and require that done never pulses.
  task automatic no_done(input string tag, input int n);
    bit any = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 if (done) any = 1'b1;
    end
    chk(tag, 32'(any), 32'd0);
  endtask

  initial begin
    int lat; bit seen, sok;
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of a MUL
    @(negedge clk); funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_stall", 32'(stall_req), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_done("midrst_no_done", 40);
    run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 32'h0000000F, 33);
    @(posedge clk); #1;
    chk("retain_done_low", 32'(done), 32'd0);
    chk("retain_result", result, 32'h0000000F);

    // Signed multiply
    run_op("mulh_m2x3", 3'b001, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 33);
    run_op("mul_m2x3", 3'b000, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, CACHE_LAT);
    run_op("mul_wrap", 3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33);

    // Signed and unsigned division
    run_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
    run_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);

    // Special cases
    run_op("divu_by0", 3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_by0", 3'b110, 32'd100, 32'd0, 32'd100, 1);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Flush a DIVU at cycle 12
    @(posedge clk); @(negedge clk);
    funct3 = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_stall", 32'(stall_req), 32'd0);
    no_done("flush_no_done", 40);

    // Back-to-back launch from DONE
    run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd6; start = 1'b1;
    #1 chk("b2b_stall_in_done", 32'(stall_req), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_busy_no_bubble", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(1, lat, seen, sok);
    chk("b2b_seen", 32'(seen), 32'd1);
    chk("b2b_latency", 32'(lat), 32'd33);
    chk("b2b_result", result, 32'd42);

    // Repeat of a completed op (cache hit when the cache is built in)
    run_op("mulhu_ff_1", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhu_ff_2", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, CACHE_LAT);
    run_op("mul_ff_after", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, CACHE_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
